// File: rtl/stack_mem_responder_if.sv
// Processor-to-memory bus for stack_mem_responder: request, write data, halt request and the response.
// The rd_cnt/wr_cnt signals exist only when ACCESS_CNT_EN is defined.
interface stack_mem_responder_if;
  logic        req;
  logic        rw;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        sys_dne;
  logic [31:0] rdata;
  logic        ack;
  logic        err;
  logic        busy;
  logic        halted;
`ifdef ACCESS_CNT_EN
  logic [15:0] rd_cnt;
  logic [15:0] wr_cnt;

  modport master (
    output req, rw, addr, wdata, sys_dne,
    input  rdata, ack, err, busy, halted, rd_cnt, wr_cnt
  );

  modport slave (
    input  req, rw, addr, wdata, sys_dne,
    output rdata, ack, err, busy, halted, rd_cnt, wr_cnt
  );
`else
  modport master (
    output req, rw, addr, wdata, sys_dne,
    input  rdata, ack, err, busy, halted
  );

  modport slave (
    input  req, rw, addr, wdata, sys_dne,
    output rdata, ack, err, busy, halted
  );
`endif
endinterface

// File: rtl/stack_mem_responder.sv
// Two-region word RAM responder (low RAM + stack RAM) with req/ack handshake, read latency and halt.
// Optional macro ACCESS_CNT_EN adds successful read/write counters.
//
// state   | meaning
// IDLE    | waiting for req; sys_dne here goes to HALT
// RD_WAIT | valid read accepted, counting down remaining latency
// RESP    | ack cycle, err and rdata valid
// HALT    | processor done; everything ignored until reset
module stack_mem_responder #(
  parameter int          LOW_WORDS   = 256,
  parameter logic [31:0] STACK_BASE  = 32'h2000_8000,
  parameter int          STACK_WORDS = 1024,
  parameter int          RD_LAT      = 2
) (
  input logic                  clk,
  input logic                  reset,
  stack_mem_responder_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_WAIT = 2'd1,
    S_RESP    = 2'd2,
    S_HALT    = 2'd3
  } state_t;

  localparam int         LO_AW     = $clog2(LOW_WORDS);
  localparam int         ST_AW     = $clog2(STACK_WORDS);
  localparam logic [1:0] WAIT_LOAD = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

  logic [31:0] lo_mem [LOW_WORDS];
  logic [31:0] st_mem [STACK_WORDS];

  state_t             state_q, state_d;
  logic [1:0]         wait_q, wait_d;
  logic               st_sel_q, st_sel_d;
  logic [LO_AW-1:0]   lo_idx_q, lo_idx_d;
  logic [ST_AW-1:0]   st_idx_q, st_idx_d;
  logic               err_q, err_d;
  logic               halt_req_q, halt_req_d;
  logic [31:0]        rdata_q, rdata_d;

  logic [31:0]        lo_word;
  logic [31:0]        st_word;
  logic               lo_hit;
  logic               st_hit;
  logic               addr_ok;
  logic [LO_AW-1:0]   lo_idx;
  logic [ST_AW-1:0]   st_idx;
  logic               accept;
  logic               mem_we;

  // Word offsets kept at full width so the range compare sees every address bit.
  assign lo_word = bus.addr >> 2;
  assign st_word = (bus.addr - STACK_BASE) >> 2;
  assign lo_hit  = lo_word < 32'(LOW_WORDS);
  assign st_hit  = (bus.addr >= STACK_BASE) && (st_word < 32'(STACK_WORDS));
  assign addr_ok = (bus.addr[1:0] == 2'b00) && (lo_hit || st_hit);
  assign lo_idx  = lo_word[LO_AW-1:0];
  assign st_idx  = st_word[ST_AW-1:0];

  assign accept = (state_q == S_IDLE) && !bus.sys_dne && bus.req;
  assign mem_we = accept && bus.rw && addr_ok && !reset;

  // RAM has no reset: contents survive a reset of the control logic.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      if (st_hit) begin
        st_mem[st_idx] <= bus.wdata;
      end else begin
        lo_mem[lo_idx] <= bus.wdata;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wait_q     <= 2'd0;
      st_sel_q   <= 1'b0;
      lo_idx_q   <= '0;
      st_idx_q   <= '0;
      err_q      <= 1'b0;
      halt_req_q <= 1'b0;
      rdata_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      st_sel_q   <= st_sel_d;
      lo_idx_q   <= lo_idx_d;
      st_idx_q   <= st_idx_d;
      err_q      <= err_d;
      halt_req_q <= halt_req_d;
      rdata_q    <= rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    st_sel_d   = st_sel_q;
    lo_idx_d   = lo_idx_q;
    st_idx_d   = st_idx_q;
    err_d      = err_q;
    halt_req_d = halt_req_q;
    rdata_d    = rdata_q;

    case (state_q)
      S_IDLE: begin
        if (bus.sys_dne) begin
          state_d = S_HALT;
        end else if (bus.req) begin
          lo_idx_d   = lo_idx;
          st_idx_d   = st_idx;
          st_sel_d   = st_hit;
          err_d      = !addr_ok;
          halt_req_d = 1'b0;
          wait_d     = WAIT_LOAD;
          if (!addr_ok) begin
            state_d = S_RESP;
            if (!bus.rw) begin
              rdata_d = 32'd0;
            end
          end else if (bus.rw) begin
            state_d = S_RESP;
          end else if (RD_LAT == 1) begin
            state_d = S_RESP;
            rdata_d = st_hit ? st_mem[st_idx] : lo_mem[lo_idx];
          end else begin
            state_d = S_RD_WAIT;
          end
        end
      end

      S_RD_WAIT: begin
        halt_req_d = halt_req_q || bus.sys_dne;
        if (wait_q == 2'd0) begin
          state_d = S_RESP;
          rdata_d = st_sel_q ? st_mem[st_idx_q] : lo_mem[lo_idx_q];
        end else begin
          wait_d = wait_q - 2'd1;
        end
      end

      S_RESP: begin
        // A done request seen at any edge of the access defers to here.
        state_d = (halt_req_q || bus.sys_dne) ? S_HALT : S_IDLE;
      end

      S_HALT: begin
        state_d = S_HALT;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.rdata  = rdata_q;
  assign bus.ack    = (state_q == S_RESP);
  assign bus.err    = (state_q == S_RESP) && err_q;
  assign bus.busy   = (state_q == S_RD_WAIT) || (state_q == S_RESP);
  assign bus.halted = (state_q == S_HALT);

`ifdef ACCESS_CNT_EN
  logic        rw_q, rw_d;
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rw_q     <= 1'b0;
      rd_cnt_q <= 16'd0;
      wr_cnt_q <= 16'd0;
    end else begin
      rw_q     <= rw_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  always_comb begin
    rw_d     = rw_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (accept) begin
      rw_d = bus.rw;
    end
    if ((state_q == S_RESP) && !err_q) begin
      if (rw_q) begin
        wr_cnt_d = wr_cnt_q + 16'd1;
      end else begin
        rd_cnt_d = rd_cnt_q + 16'd1;
      end
    end
  end

  assign bus.rd_cnt = rd_cnt_q;
  assign bus.wr_cnt = wr_cnt_q;
`endif

endmodule

// File: tb/tb_stack_mem_responder.sv
// Scoreboard bench for stack_mem_responder: directed accesses push expected responses, a monitor checks each ack.
module tb_stack_mem_responder;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  stack_mem_responder_if bus();

  stack_mem_responder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every ack must match the oldest outstanding expectation.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1 && bus.ack === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("spurious_ack", 32'(exp_q.size()), 32'd1);
        end else begin
          x = exp_q.pop_front();
          check("resp_err", 32'(bus.err), 32'(x.err));
          check("resp_rdata", bus.rdata, x.rdata);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic access(input string tag, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic e, input logic [31:0] rd,
                        input int lat, input bit hold_req, input bit dne_in_wait);
    exp_t x;
    int   got;
    @(negedge clk);
    bus.req   = 1'b1;
    bus.rw    = w;
    bus.addr  = a;
    bus.wdata = d;
    x.err     = e;
    x.rdata   = rd;
    exp_q.push_back(x);
    got = 0;
    for (int k = 0; k < 12 && got == 0; k++) begin
      @(negedge clk);
      if (!hold_req) bus.req = 1'b0;
      if (dne_in_wait && k == 0) bus.sys_dne = 1'b1;
      check({tag, "_busy"}, 32'(bus.busy), 32'd1);
      if (bus.ack === 1'b1) begin
        got = k + 1;
        bus.req = 1'b0;
      end
    end
    check({tag, "_latency"}, 32'(got), 32'(lat));
    @(negedge clk);
    check({tag, "_busy_after"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    bus.req     = 1'b0;
    bus.rw      = 1'b0;
    bus.addr    = 32'd0;
    bus.wdata   = 32'd0;
    bus.sys_dne = 1'b0;
    reset       = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ack",    32'(bus.ack),    32'd0);
    check("rst_err",    32'(bus.err),    32'd0);
    check("rst_busy",   32'(bus.busy),   32'd0);
    check("rst_halted", 32'(bus.halted), 32'd0);
    check("rst_rdata",  bus.rdata,       32'd0);
    reset = 1'b0;

    //      tag        rw    addr           wdata          err   rdata          lat hold dne
    access("w_stk",    1'b1, 32'h20008C78, 32'h00000128, 1'b0, 32'h00000000, 1, 0, 0);
    access("r_stk",    1'b0, 32'h20008C78, 32'h0,        1'b0, 32'h00000128, 2, 0, 0);
    access("w_low",    1'b1, 32'h00000004, 32'h8DE09123, 1'b0, 32'h00000128, 1, 0, 0);
    access("r_low",    1'b0, 32'h00000004, 32'h0,        1'b0, 32'h8DE09123, 2, 0, 0);
    access("r_stk2",   1'b0, 32'h20008C78, 32'h0,        1'b0, 32'h00000128, 2, 0, 0);
    access("r_mis",    1'b0, 32'h00000006, 32'h0,        1'b1, 32'h00000000, 1, 0, 0);
    access("r_unmap",  1'b0, 32'h10000000, 32'h0,        1'b1, 32'h00000000, 1, 0, 0);
    access("r_low2",   1'b0, 32'h00000004, 32'h0,        1'b0, 32'h8DE09123, 2, 0, 0);
    access("w_lowtop", 1'b1, 32'h000003FC, 32'hA5A55A5A, 1'b0, 32'h8DE09123, 1, 0, 0);
    access("w_stktop", 1'b1, 32'h20008FFC, 32'h0BADF00D, 1'b0, 32'h8DE09123, 1, 0, 0);
    access("w_stkend", 1'b1, 32'h20009000, 32'hFFFFFFFF, 1'b1, 32'h8DE09123, 1, 0, 0);
    access("w_lowend", 1'b1, 32'h00000400, 32'h11111111, 1'b1, 32'h8DE09123, 1, 0, 0);
    access("w_mis",    1'b1, 32'h2000800E, 32'h22222222, 1'b1, 32'h8DE09123, 1, 0, 0);
    access("r_lowtop", 1'b0, 32'h000003FC, 32'h0,        1'b0, 32'hA5A55A5A, 2, 0, 0);
    access("r_below",  1'b0, 32'h20007FFC, 32'h0,        1'b1, 32'h00000000, 1, 0, 0);
    access("r_hold",   1'b0, 32'h20008FFC, 32'h0,        1'b0, 32'h0BADF00D, 2, 1, 0);
    access("r_dne",    1'b0, 32'h20008C78, 32'h0,        1'b0, 32'h00000128, 2, 0, 1);

    check("halt_entered", 32'(bus.halted), 32'd1);
    bus.sys_dne = 1'b0;
    bus.req     = 1'b1;
    bus.rw      = 1'b0;
    bus.addr    = 32'h00000004;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("halt_hold", 32'(bus.halted), 32'd1);
      check("halt_busy", 32'(bus.busy),   32'd0);
    end
    bus.req = 1'b0;

    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst2_halted", 32'(bus.halted), 32'd0);
    check("rst2_rdata",  bus.rdata,       32'd0);
    check("rst2_ack",    32'(bus.ack),    32'd0);
    check("rst2_busy",   32'(bus.busy),   32'd0);
    @(negedge clk);
    reset = 1'b0;

    access("r_keep",   1'b0, 32'h20008C78, 32'h0,        1'b0, 32'h00000128, 2, 0, 0);
    access("r_keep2",  1'b0, 32'h000003FC, 32'h0,        1'b0, 32'hA5A55A5A, 2, 0, 0);

`ifdef ACCESS_CNT_EN
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("cnt_rst_wr", 32'(bus.wr_cnt), 32'd0);
    check("cnt_rst_rd", 32'(bus.rd_cnt), 32'd0);
    access("c_w1",     1'b1, 32'h00000008, 32'h00000001, 1'b0, 32'h00000000, 1, 0, 0);
    access("c_w2",     1'b1, 32'h0000000C, 32'h00000002, 1'b0, 32'h00000000, 1, 0, 0);
    access("c_w3",     1'b1, 32'h20008000, 32'h00000003, 1'b0, 32'h00000000, 1, 0, 0);
    access("c_r1",     1'b0, 32'h00000008, 32'h0,        1'b0, 32'h00000001, 2, 0, 0);
    access("c_r2",     1'b0, 32'h20008000, 32'h0,        1'b0, 32'h00000003, 2, 0, 0);
    access("c_rmis",   1'b0, 32'h00000009, 32'h0,        1'b1, 32'h00000000, 1, 0, 0);
    check("cnt_wr", 32'(bus.wr_cnt), 32'd3);
    check("cnt_rd", 32'(bus.rd_cnt), 32'd2);
`endif

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stack_mem_responder.md
Name: stack_mem_responder

Overview:
- Memory-side responder for the processor's bus: `addr`, `out`→`wdata`, `rw`, `sys_dne`, with the returned word driving the processor's `instruction` input.
- Serves two word-addressed regions: low program/data RAM at 0x00000000 and stack RAM at STACK_BASE. Push and pop traffic lands in the stack region.
- Adds a request/acknowledge handshake with configurable read latency, error reporting for misaligned or unmapped accesses, and a halt state entered on `sys_dne`.

Parameters:
- LOW_WORDS, 256: word count of the low region; byte range 0x00000000 .. 4*LOW_WORDS-4.
- STACK_BASE, 32'h20008000: byte base of the stack region; must be word aligned.
- STACK_WORDS, 1024: word count of the stack region; default range 0x20008000..0x20008FFC.
- RD_LAT, 2: cycles from read acceptance to ack. Legal range 1..4.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  access request, sampled only in IDLE.
- rw  in  1  1 = write, 0 = read; captured at acceptance.
- addr  in  32  byte address; captured at acceptance.
- wdata  in  32  write data (processor `out`); captured at acceptance.
- sys_dne  in  1  processor done; requests a halt.
- rdata  out  32  read data (to processor `instruction`).
- ack  out  1  one-cycle completion pulse.
- err  out  1  valid with ack; 1 = access rejected.
- busy  out  1  high from acceptance until and including the ack cycle.
- halted  out  1  high in HALT.

Behaviour:
- Reset (asynchronous):
  - Outputs: rdata=0, ack=0, err=0, busy=0, halted=0; state=IDLE.
  - RAM contents are not cleared. Words already written stay written.
- State machine states: IDLE, RD_WAIT, RESP, HALT.
- IDLE:
  - sys_dne=1 at an edge → HALT; req is ignored that cycle.
  - Otherwise req=1 at an edge → accept; latch addr, rw, wdata.
- Address check at acceptance:
  - Valid = addr[1:0]==0 AND addr falls in the low region or the stack region.
  - Index = (addr − region base) >> 2.
- Valid write:
  - RAM updated at the acceptance edge; next state RESP.
  - In RESP: ack=1, err=0. rdata unchanged.
- Valid read:
  - RD_WAIT counts RD_LAT−1 cycles; RD_LAT=1 goes straight to RESP.
  - In RESP: ack=1, err=0, rdata=RAM word.
  - ack appears exactly RD_LAT cycles after the acceptance edge.
- Invalid access:
  - No RAM change; next state RESP.
  - In RESP: ack=1, err=1. rdata=0 for a read; rdata unchanged for a write.
- RESP → IDLE, or → HALT if sys_dne was seen at any edge since acceptance.
- rdata holds its value until the next read completes.
- busy=1 in RD_WAIT and RESP, so req is ignored while busy. A new request cannot be accepted in the RESP cycle; the earliest acceptance is the edge after RESP.
- HALT:
  - halted=1, busy=0, ack=0; all requests ignored.
  - Exit only via reset.
- Reset during RD_WAIT or RESP aborts the access: no ack is issued, and a write already committed at acceptance stays committed.
- Reads of never-written words return X in simulation; benches write before reading.

Optional Feature:
- Macro: ACCESS_CNT_EN.
- When defined:
  - Adds outputs rd_cnt[15:0] and wr_cnt[15:0], reset to 0.
  - Each increments in the RESP cycle of a successful (err=0) read or write, and wraps 0xFFFF→0.
  - err accesses are not counted.
- When undefined: neither port nor counter exists; the rest of the behaviour is identical.

Test Plan:
- Write 0x00000128 to 0x20008C78, then read it back with RD_LAT=2 → write ack 1 cycle after acceptance (err=0). Read ack exactly 2 cycles after acceptance with rdata=0x00000128.
- Write 0x8DE09123 to 0x00000004, read 0x00000004, then read 0x20008C78 → rdata=0x8DE09123, then 0x00000128. This confirms region independence.
- Read 0x00000006, then read 0x10000000 → both ack with err=1 and rdata=0. A following read of 0x00000004 still returns 0x8DE09123.
- Pulse req every cycle during a read → only the first is accepted, busy=1 until ack, and there is exactly one ack per accepted access.
- Assert sys_dne during RD_WAIT → read completes with correct data, then halted=1 and later req has no effect. Asserting reset then clears halted and outputs while RAM keeps 0x00000128 at 0x20008C78.
- ACCESS_CNT_EN defined: 3 good writes, 2 good reads, 1 misaligned read → wr_cnt=3, rd_cnt=2.
